// File: rtl/worldmap_arbiter.sv
// worldmap_arbiter
// Shares the single-port 128x128 world-map ROM between the video raster path
// and the robot lookup path. Video owns the port during active video; robot
// reads go through in blanking, or steal one video slot after MAX_WAIT cycles.

module worldmap_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 2,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_active,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              bot_req,
    input  logic [ADDR_W-1:0] bot_addr,
    output logic              bot_ack,
    output logic [DATA_W-1:0] bot_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [15:0]       steal_cnt
);

    // Robot transaction phases: ARB decides the port owner, DATA captures the
    // ROM word, DONE presents the ack pulse.
    localparam logic [1:0] ST_ARB  = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0]  WAIT_LIMIT = 8'(MAX_WAIT);
    localparam logic [15:0] STEAL_MAX  = 16'hFFFF;

    logic [1:0]        r_state;
    logic [7:0]        r_wait_cnt;
    logic [15:0]       r_steal_cnt;
    logic              r_bot_ack;
    logic [DATA_W-1:0] r_bot_data;
    logic              r_vid_gnt_q;
    logic              r_vid_act_q;
    logic              r_vid_valid;
    logic [DATA_W-1:0] r_vid_data;

    logic              w_in_arb;
    logic              w_wait_expired;
    logic              w_grant_bot;

    // The robot wins the port in ARB when video is blanked, or once it has
    // waited long enough during active video.
    assign w_in_arb       = (r_state == ST_ARB);
    assign w_wait_expired = (r_wait_cnt == WAIT_LIMIT);
    assign w_grant_bot    = w_in_arb & bot_req & (~vid_active | w_wait_expired);

    // Port mux stays combinational so the ROM sees the winner's address in
    // the grant cycle, reset included.
    assign rom_addr = w_grant_bot ? bot_addr : vid_addr;

    // Transaction sequencing, wait counting and stolen-slot accounting.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all state updates see the
        // pre-edge values; blocking assignments would race with other blocks.
        if (reset) begin
            r_state     <= ST_ARB;
            r_wait_cnt  <= 8'd0;
            r_steal_cnt <= 16'd0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_grant_bot) begin
                        r_state    <= ST_DATA;
                        r_wait_cnt <= 8'd0;
                        if (vid_active && (r_steal_cnt != STEAL_MAX))
                            r_steal_cnt <= r_steal_cnt + 16'd1;
                    end else if (bot_req) begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end else begin
                        r_wait_cnt <= 8'd0;
                    end
                end
                ST_DATA: r_state <= ST_DONE;
                ST_DONE: r_state <= ST_ARB;
                default: r_state <= ST_ARB;
            endcase
        end
    end

    // Robot result: capture the ROM word one cycle after the grant and pulse
    // the ack for exactly the DONE cycle; the data holds until the next ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bot_ack  <= 1'b0;
            r_bot_data <= '0;
        end else begin
            r_bot_ack <= (r_state == ST_DATA);
            if (r_state == ST_DATA)
                r_bot_data <= rom_data;
        end
    end

    // Video pipeline: track whether the ROM word arriving now belongs to
    // video; a stolen slot keeps the previous pixel word and drops valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vid_gnt_q <= 1'b1;
            r_vid_act_q <= 1'b0;
            r_vid_valid <= 1'b0;
            r_vid_data  <= '0;
        end else begin
            r_vid_gnt_q <= ~w_grant_bot;
            r_vid_act_q <= vid_active;
            r_vid_valid <= r_vid_gnt_q & r_vid_act_q;
            if (r_vid_gnt_q)
                r_vid_data <= rom_data;
        end
    end

    assign vid_data  = r_vid_data;
    assign vid_valid = r_vid_valid;
    assign bot_ack   = r_bot_ack;
    assign bot_data  = r_bot_data;
    assign steal_cnt = r_steal_cnt;

endmodule

// File: tb/tb_worldmap_arbiter.sv
// tb_worldmap_arbiter
// Scoreboard bench: the driver applies one cycle of stimulus, asks a
// transaction-level model what the arbiter must do, and queues the expected
// responses tagged with the cycle they are due. A separate monitor compares
// the DUT outputs against the queues on the falling edge.

module tb_worldmap_arbiter;

    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 2;
    localparam int MAX_WAIT = 16;

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic              vid_active = 1'b0;
    logic [ADDR_W-1:0] vid_addr   = '0;
    logic              bot_req    = 1'b0;
    logic [ADDR_W-1:0] bot_addr   = '0;
    logic [DATA_W-1:0] rom_data   = '0;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic              bot_ack;
    logic [DATA_W-1:0] bot_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       steal_cnt;

    worldmap_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vid_active(vid_active),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .bot_req   (bot_req),
        .bot_addr  (bot_addr),
        .bot_ack   (bot_ack),
        .bot_data  (bot_data),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .steal_cnt (steal_cnt)
    );

    always #5 clk = ~clk;

    // ROM stand-in: word is the low two bits of the previous cycle's address.
    always @(posedge clk) rom_data <= rom_addr[1:0];

    // Cycle number; cycle c runs from the c-th rising edge to the next one.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [ADDR_W-1:0] addr; }                rom_exp_t;
    typedef struct { int cyc; logic valid; logic [DATA_W-1:0] data; }   vid_exp_t;
    typedef struct { int cyc; logic [15:0] steal; logic [DATA_W-1:0] bdata; } reg_exp_t;
    typedef struct { int cyc; logic [DATA_W-1:0] data; }                bot_exp_t;

    rom_exp_t q_rom[$];
    vid_exp_t q_vid[$];
    reg_exp_t q_reg[$];
    bot_exp_t q_bot[$];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    int              free_from  = 0;   // first cycle the arbiter can grant again
    int              req_start  = 0;   // cycle the current unserved request began
    bit              waiting    = 1'b0;
    int              steal_m    = 0;
    logic [DATA_W-1:0] bdata_m  = '0;
    logic [DATA_W-1:0] vdata_m  = '0;
    bit              pend       = 1'b0;
    int              pend_cyc   = 0;
    logic [DATA_W-1:0] pend_val = '0;
    bit              prev_rst   = 1'b1;
    bit              prev_grant = 1'b0;
    bit              prev_act   = 1'b0;
    logic [ADDR_W-1:0] prev_rom = '0;

    // Apply one cycle of stimulus and queue what the arbiter owes for it.
    task automatic drive(input bit rst, input bit act, input logic [ADDR_W-1:0] va,
                         input bit rq, input logic [ADDR_W-1:0] ba);
        int c;
        bit in_arb;
        bit grant;
        bit vv;
        logic [ADDR_W-1:0] ea;
        @(posedge clk);
        #1;
        reset      = rst;
        vid_active = act;
        vid_addr   = va;
        bot_req    = rq;
        bot_addr   = ba;
        c = cyc;

        // Who owns the ROM this cycle.
        in_arb = (c >= free_from);
        if (in_arb && rq && !waiting) begin
            waiting   = 1'b1;
            req_start = c;
        end
        grant = in_arb && rq && (!act || (c - req_start) == MAX_WAIT);
        ea    = grant ? ba : va;
        q_rom.push_back('{c, ea});

        // Video word due next cycle comes from last cycle's ROM access.
        vv = !rst && !prev_rst && !prev_grant && prev_act;
        if (rst)
            vdata_m = '0;
        else if (prev_rst || !prev_grant)
            vdata_m = prev_rom[DATA_W-1:0];
        q_vid.push_back('{c + 1, vv, vdata_m});

        // Robot transaction bookkeeping.
        if (rst) begin
            if (q_bot.size() > 0 && q_bot[$].cyc == c + 1)
                void'(q_bot.pop_back());
            pend      = 1'b0;
            free_from = c + 1;
            waiting   = 1'b0;
            steal_m   = 0;
            bdata_m   = '0;
        end else begin
            if (pend && pend_cyc == c + 1) begin
                bdata_m = pend_val;
                pend    = 1'b0;
            end
            if (grant) begin
                q_bot.push_back('{c + 2, ba[DATA_W-1:0]});
                pend      = 1'b1;
                pend_cyc  = c + 2;
                pend_val  = ba[DATA_W-1:0];
                free_from = c + 3;
                waiting   = 1'b0;
                if (act && steal_m < 16'hFFFF)
                    steal_m++;
            end else if (in_arb && !rq) begin
                waiting = 1'b0;
            end
        end
        q_reg.push_back('{c + 1, 16'(steal_m), bdata_m});

        prev_rst   = rst;
        prev_grant = grant;
        prev_act   = act;
        prev_rom   = ea;
    endtask

    // Monitor: compare whatever the DUT presents against the due expectations.
    initial begin
        rom_exp_t re;
        vid_exp_t ve;
        reg_exp_t ge;
        bot_exp_t be;
        forever begin
            @(negedge clk);
            if (q_rom.size() > 0 && q_rom[0].cyc == cyc) begin
                re = q_rom.pop_front();
                check("rom_addr", 32'(rom_addr), 32'(re.addr));
            end
            if (q_vid.size() > 0 && q_vid[0].cyc == cyc) begin
                ve = q_vid.pop_front();
                check("vid_valid", 32'(vid_valid), 32'(ve.valid));
                check("vid_data", 32'(vid_data), 32'(ve.data));
            end
            if (q_reg.size() > 0 && q_reg[0].cyc == cyc) begin
                ge = q_reg.pop_front();
                check("steal_cnt", 32'(steal_cnt), 32'(ge.steal));
                check("bot_data_held", 32'(bot_data), 32'(ge.bdata));
            end
            if (bot_ack === 1'b1) begin
                if (q_bot.size() == 0) begin
                    check("bot_ack_unexpected", 32'(bot_ack), 32'd0);
                end else begin
                    be = q_bot.pop_front();
                    check("bot_ack_cycle", 32'(cyc), 32'(be.cyc));
                    check("bot_data_at_ack", 32'(bot_data), 32'(be.data));
                end
            end else if (q_bot.size() > 0 && q_bot[0].cyc <= cyc) begin
                be = q_bot.pop_front();
                check("bot_ack_missing", 32'(bot_ack), 32'd1);
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        bit r_act;
        bit r_req;
        logic [ADDR_W-1:0] r_ba;
        logic [ADDR_W-1:0] va;
        logic [ADDR_W-1:0] ba;
        r_act = 1'b0;
        r_req = 1'b0;
        r_ba  = '0;

        // Reset held three cycles with random inputs.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'($urandom_range(1)), 14'($urandom_range(16383)),
                  1'($urandom_range(1)), 14'($urandom_range(16383)));
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b0, '0, 1'b0, '0);

        // Blanking read of 0x0ABE.
        drive(1'b0, 1'b0, '0, 1'b1, 14'h0ABE);
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b0, '0, 1'b0, 14'h0ABE);

        // Video stream, then a robot request that must steal a slot.
        for (int i = 0; i < 8; i++)
            drive(1'b0, 1'b1, 14'(i), 1'b0, '0);
        for (int i = 0; i < 24; i++)
            drive(1'b0, 1'b1, 14'(8 + i), (i <= 18), 14'h0003);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        drive(1'b0, 1'b0, '0, 1'b0, '0);

        // Back-to-back blanking reads of 5, 6, 7.
        for (int k = 0; k < 10; k++) begin
            ba = (k <= 2) ? 14'd5 : (k <= 5) ? 14'd6 : 14'd7;
            drive(1'b0, 1'b0, '0, (k <= 8), ba);
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0);

        // Reset landing on the DATA cycle of a transaction.
        drive(1'b0, 1'b0, '0, 1'b1, 14'd1);
        drive(1'b1, 1'b0, '0, 1'b0, 14'd1);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b0, '0, 1'b0, '0);

        // Randomized traffic: long video/blanking runs, sporadic robot reads,
        // occasional held requests, abandoned requests and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63) == 0)
                r_act = !r_act;
            if (r_req) begin
                if (bot_ack === 1'b1)
                    r_req = ($urandom_range(3) == 0);
                else if ($urandom_range(63) == 0)
                    r_req = 1'b0;
            end else if ($urandom_range(7) == 0) begin
                r_req = 1'b1;
                r_ba  = 14'($urandom_range(16383));
            end
            va = 14'($urandom_range(16383));
            drive(($urandom_range(255) == 0), r_act, va, r_req, r_ba);
        end

        for (int i = 0; i < 6; i++)
            drive(1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        #1;
        check("bot_acks_outstanding", 32'(q_bot.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
